s27_bist_ctrl: RTL and testbench
================================

// Module: s27_bist_ctrl
// PURPOSE
//  Built-in self-test controller wrapped around the s27 core: stimulus generator upstream
//  of s27 inputs G0..G3, signature compactor downstream of output G17.
//  Flushes s27's unreset DFF state to a known value, then applies N_PATTERNS LFSR patterns
//  and compacts G17 into a 16-bit serial signature. Compares the result to GOLDEN_SIG.
// PARAMETERS
//  N_PATTERNS    255      patterns applied in RUN; legal range 1..65535
//  FLUSH_CYCLES  2        cycles of flush pattern before RUN; legal range 1..15
//  LFSR_SEED     8'h01    LFSR value loaded on FLUSH entry; 8'h00 is replaced by 8'h01
//  GOLDEN_SIG    16'h0000 expected signature; set per configuration at integration
// PORTS
//  CK         in   1   clock; all logic is rising-edge
//  RST        in   1   synchronous, active-high reset
//  START      in   1   level; sampled only in IDLE or DONE
//  G0..G3     out  1   each; registered stimulus to s27 inputs G0..G3
//  G17        in   1   s27 output; combinational function of G0..G3 and s27 state
//  BUSY       out  1   high in FLUSH and RUN
//  DONE       out  1   high in DONE; sticky until the next START
//  PASS       out  1   valid only while DONE=1; SIGNATURE == GOLDEN_SIG
//  SIGNATURE  out  16  SISR contents
// BEHAVIOUR
//  - Reset (RST=1 at an edge, any state): state=IDLE; G0..G3=0, BUSY=0, DONE=0, PASS=0,
//    SIGNATURE=16'h0000, pattern counter=0. RST has priority over START.
//  - FSM: IDLE -(START)-> FLUSH -(FLUSH_CYCLES done)-> RUN -(N_PATTERNS done)-> DONE
//    -(START)-> FLUSH. START is ignored in FLUSH and RUN.
//  - FLUSH entry: LFSR loaded with LFSR_SEED; SISR loaded with 16'hFFFF.
//  - In FLUSH, drive G0=1, G1=1, G2=0, G3=0. Hold this for FLUSH_CYCLES cycles. This forces
//    the s27 internal state to G5=1, G6=0, G7=1 after one edge. SISR does not shift.
//  - RUN cycle i (i=0..N_PATTERNS-1): {G3,G2,G1,G0} = LFSR[3:0].
//    At the closing edge of cycle i:
//      - SISR shifts in G17.
//      - LFSR advances.
//      - 16-bit counter increments.
//    Leave RUN at the edge where the counter reaches N_PATTERNS-1.
//  - LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; fb = L[7]^L[5]^L[4]^L[3];
//    L <= {L[6:0], fb}. Period 255; patterns repeat for N_PATTERNS > 255.
//  - SISR: CRC-CCITT, x^16+x^12+x^5+1; fb = S[15]^G17;
//    S <= {S[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
//  - Latency: G17 is sampled at the same edge that retires the pattern driving it.
//    The block adds no pipeline stage between G0..G3 and G17.
//  - DONE state: G0..G3=0, BUSY=0, DONE=1, PASS=(SIGNATURE==GOLDEN_SIG). SIGNATURE holds.
//  - Restart from DONE with START=1: enter FLUSH next edge. DONE and PASS drop at that edge.
//    Re-seed and re-init as on first start.
//  - START held high continuously: the test reruns back-to-back, passing through DONE for
//    exactly one cycle.
//  - Total BUSY duration: FLUSH_CYCLES + N_PATTERNS cycles. DONE rises on the following edge.
// STRUCTURE
//  - Package s27_bist_pkg holds:
//      - state enum {IDLE, FLUSH, RUN, DONE};
//      - LFSR tap constant 8'hB8;
//      - SISR poly 16'h1021 and init 16'hFFFF;
//      - flush pattern 4'b0011 as {G3,G2,G1,G0}.
//  - Sub-module s27_lfsr8 has ports CK, RST, LOAD, SEED[7:0], EN, Q[7:0].
//    It contains the seed-zero substitution. The FSM, counter and SISR stay in the top level.
// TESTING (bench instantiates s27 + s27_bist_ctrl; C-model of s27, LFSR, SISR as reference)
//  1. Reset values:
//     - Stimulus: RST=1 for 3 cycles.
//     - Response: G0..G3=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=16'h0000.
//  2. Flush and first patterns:
//     - Stimulus: N_PATTERNS=4, FLUSH_CYCLES=2, seed 8'h01, one-cycle START.
//     - Response: BUSY for 6 cycles. FLUSH drives {G3..G0}=4'b0011 for 2 cycles.
//       s27 state is then G5=1, G6=0, G7=1. RUN drives 4'h1, 4'h2, 4'h4, 4'h8.
//       DONE=1 on the 7th edge after START.
//  3. Signature and PASS:
//     - Stimulus: default N_PATTERNS=255, GOLDEN_SIG set to the model signature.
//     - Response: DONE=1, PASS=1, SIGNATURE equals the model value.
//     - Stimulus: rerun with GOLDEN_SIG XOR 16'h0001.
//     - Response: PASS=0.
//  4. Mid-run events:
//     - Stimulus: START pulse at RUN cycle 10.
//     - Response: ignored; total BUSY unchanged.
//     - Stimulus: RST at RUN cycle 10.
//     - Response: next cycle IDLE with all outputs at reset values.
//     - Stimulus: new START after the reset.
//     - Response: a full run with a correct signature.
//  5. Restart and limits:
//     - Stimulus: START held high.
//     - Response: DONE high exactly one cycle between runs; identical signatures.
//     - Stimulus: N_PATTERNS=1.
//     - Response: one pattern, 4'h1.
//     - Stimulus: LFSR_SEED=8'h00.
//     - Response: behaves as seed 8'h01.
//     - Stimulus: N_PATTERNS=300.
//     - Response: pattern 255 equals pattern 0.

Source files
------------

// File: rtl/s27_bist_pkg.sv
// ============================================================================
// s27_bist_pkg
// Shared types and constants for the s27 BIST controller:
//   - state_e     : controller states
//   - LFSR_TAPS   : feedback taps of the 8-bit Fibonacci pattern generator
//   - SISR_POLY   : CRC-CCITT polynomial of the 16-bit signature register
//   - SISR_INIT   : signature register value loaded when a test starts
//   - FLUSH_PAT   : {G3,G2,G1,G0} applied while flushing the s27 state
//   - lfsr8_fb()  : pattern generator feedback bit
//   - sisr_next() : one signature register shift
// ============================================================================
package s27_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1  ->  feedback from bits 7,5,4,3
    localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
    // An all-zero LFSR would lock up, so a zero seed is replaced by this value
    localparam logic [7:0]  LFSR_SEED_SUB = 8'h01;

    localparam logic [15:0] SISR_POLY     = 16'h1021;
    localparam logic [15:0] SISR_INIT     = 16'hFFFF;

    // G0=1, G1=1, G2=0, G3=0 forces s27 to G5=1, G6=0, G7=1 after one edge
    localparam logic [3:0]  FLUSH_PAT     = 4'b0011;

    function automatic logic lfsr8_fb(input logic [7:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

    function automatic logic [15:0] sisr_next(input logic [15:0] s, input logic d);
        return {s[14:0], 1'b0} ^ ((s[15] ^ d) ? SISR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/s27_lfsr8.sv
// ============================================================================
// s27_lfsr8
// 8-bit Fibonacci LFSR producing the s27 stimulus patterns.
// Ports:
//   CK    in  1  clock, rising edge
//   RST   in  1  synchronous active-high reset
//   LOAD  in  1  load SEED (a zero seed is substituted by 8'h01); wins over EN
//   SEED  in  8  seed value
//   EN    in  1  advance one step
//   Q     out 8  current LFSR contents
// ============================================================================
module s27_lfsr8
    import s27_bist_pkg::*;
(
    input  logic       CK,
    input  logic       RST,
    input  logic       LOAD,
    input  logic [7:0] SEED,
    input  logic       EN,
    output logic [7:0] Q
);

    logic [7:0] r_q;
    logic [7:0] w_seed;

    assign w_seed = (SEED == 8'h00) ? LFSR_SEED_SUB : SEED;

    always_ff @(posedge CK) begin
        if (RST) begin
            r_q <= LFSR_SEED_SUB;
        end else if (LOAD) begin
            r_q <= w_seed;
        end else if (EN) begin
            r_q <= {r_q[6:0], lfsr8_fb(r_q)};
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/s27_bist_ctrl.sv
// ============================================================================
// s27_bist_ctrl
// BIST controller around the ISCAS s27 core. On START it flushes the s27
// flip-flops with a fixed pattern, applies N_PATTERNS LFSR patterns to
// G0..G3, compacts G17 into a 16-bit CRC-CCITT signature and reports
// whether the signature matches GOLDEN_SIG.
// Ports:
//   CK         in   1  clock, rising edge
//   RST        in   1  synchronous active-high reset (priority over START)
//   START      in   1  level; only looked at in IDLE and DONE
//   G0..G3     out  1  registered stimulus to the s27 inputs
//   G17        in   1  s27 output (combinational from G0..G3 and s27 state)
//   BUSY       out  1  high during FLUSH and RUN
//   DONE       out  1  high in DONE until the next START
//   PASS       out  1  SIGNATURE == GOLDEN_SIG, meaningful while DONE=1
//   SIGNATURE  out 16  signature register contents
// ============================================================================
module s27_bist_ctrl
    import s27_bist_pkg::*;
#(
    parameter int unsigned N_PATTERNS   = 255,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED    = 8'h01,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        START,
    output logic        G0,
    output logic        G1,
    output logic        G2,
    output logic        G3,
    input  logic        G17,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] SIGNATURE
);

    state_e      r_state;
    state_e      w_state_nxt;

    logic [15:0] r_cnt;
    logic [3:0]  r_fcnt;
    logic [15:0] r_sisr;
    logic [3:0]  r_g;
    logic [3:0]  w_g_nxt;

    logic        w_lfsr_load;
    logic        w_lfsr_en;
    logic [7:0]  w_lfsr_q;
    logic [3:0]  w_lfsr_nxt_lo;

    logic        w_cnt_last;
    logic        w_flush_last;

    // ------------------------------------------------------------------
    // Pattern generator
    // ------------------------------------------------------------------
    s27_lfsr8 u_lfsr (
        .CK   (CK),
        .RST  (RST),
        .LOAD (w_lfsr_load),
        .SEED (LFSR_SEED),
        .EN   (w_lfsr_en),
        .Q    (w_lfsr_q)
    );

    // Low nibble of the LFSR value after the next step. The G outputs are
    // registered, so in RUN they are loaded with the pattern the LFSR will
    // hold after the same edge.
    assign w_lfsr_nxt_lo = {w_lfsr_q[2:0], lfsr8_fb(w_lfsr_q)};

    assign w_cnt_last   = (r_cnt  == 16'(N_PATTERNS - 1));
    assign w_flush_last = (r_fcnt == 4'(FLUSH_CYCLES - 1));

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_load = 1'b0;
        w_lfsr_en   = 1'b0;
        w_g_nxt     = 4'b0000;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_state_nxt = ST_FLUSH;
                    w_lfsr_load = 1'b1;
                    w_g_nxt     = FLUSH_PAT;
                end
            end

            ST_FLUSH: begin
                if (w_flush_last) begin
                    // LFSR already holds the (substituted) seed: pattern 0
                    w_state_nxt = ST_RUN;
                    w_g_nxt     = w_lfsr_q[3:0];
                end else begin
                    w_g_nxt     = FLUSH_PAT;
                end
            end

            ST_RUN: begin
                w_lfsr_en = 1'b1;
                if (w_cnt_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_g_nxt     = w_lfsr_nxt_lo;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, stimulus and signature registers
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_g     <= 4'b0000;
            r_cnt   <= 16'h0000;
            r_fcnt  <= 4'h0;
            r_sisr  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;

            if (w_lfsr_load) begin
                r_cnt  <= 16'h0000;
                r_fcnt <= 4'h0;
                r_sisr <= SISR_INIT;
            end else if (r_state == ST_FLUSH) begin
                r_fcnt <= r_fcnt + 4'h1;
            end else if (r_state == ST_RUN) begin
                // G17 reflects the pattern retiring at this edge
                r_sisr <= sisr_next(r_sisr, G17);
                r_cnt  <= r_cnt + 16'h0001;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign G0        = r_g[0];
    assign G1        = r_g[1];
    assign G2        = r_g[2];
    assign G3        = r_g[3];
    assign BUSY      = (r_state == ST_FLUSH) || (r_state == ST_RUN);
    assign DONE      = (r_state == ST_DONE);
    assign PASS      = (r_state == ST_DONE) && (r_sisr == GOLDEN_SIG);
    assign SIGNATURE = r_sisr;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Bench for s27_bist_ctrl: six controller instances with different
// parameter sets, each wrapped around a behavioural s27 core. A stimulus
// process queues the expected signature/PASS per test start; per-instance
// monitors check flush/run patterns, s27 state after flush, BUSY length and
// pop the expectation when DONE rises.
module tb_s27_bist_ctrl;

    localparam int NI = 6;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
    } exp_t;

    // ---------------- reference model ----------------
    // s27 netlist: returns {G17, G7', G6', G5'} for inputs gi={G3..G0}, st={G7,G6,G5}
    function automatic logic [3:0] s27_step(input logic [3:0] gi, input logic [2:0] st);
        logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
        g14 = ~gi[0];
        g8  = g14 & st[1];
        g12 = ~(gi[1] | st[2]);
        g15 = g12 | g8;
        g16 = gi[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(st[0] | g9);
        g10 = ~(g14 | g11);
        g13 = ~(gi[2] | g12);
        return {~g11, g13, g11, g10};
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] fix_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    // Signature after n patterns, starting from the flushed s27 state G5=1,G6=0,G7=1
    function automatic logic [15:0] model_sig(input int n, input logic [7:0] seed);
        logic [7:0]  l;
        logic [15:0] s;
        logic [2:0]  st;
        logic [3:0]  r;
        logic        fb;
        l  = fix_seed(seed);
        s  = 16'hFFFF;
        st = 3'b101;
        for (int i = 0; i < n; i++) begin
            r  = s27_step(l[3:0], st);
            fb = s[15] ^ r[3];
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            st = r[2:0];
            l  = lfsr_adv(l);
        end
        return s;
    endfunction

    localparam logic [15:0] GOLD = model_sig(255, 8'h01);

    function automatic int np_of(input int k);
        case (k)
            0: return 4;
            3: return 1;
            4: return 4;
            5: return 300;
            default: return 255;
        endcase
    endfunction

    function automatic int fc_of(input int k);
        case (k)
            4: return 3;
            5: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] sd_of(input int k);
        case (k)
            4: return 8'h00;
            5: return 8'h5A;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [15:0] gs_of(input int k);
        case (k)
            1: return GOLD;
            2: return GOLD ^ 16'h0001;
            default: return 16'h0000;
        endcase
    endfunction

    // ---------------- signals ----------------
    logic            clk = 1'b0;
    logic [NI-1:0]   rst;
    logic [NI-1:0]   start;
    logic [NI-1:0]   g17;
    logic [NI-1:0]   busy;
    logic [NI-1:0]   done;
    logic [NI-1:0]   pass;
    logic [3:0]      g   [NI];
    logic [15:0]     sig [NI];

    exp_t            exp_q [NI][$];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s u%0d: got %0h, expected %0h (t=%0t)", nm, k, act, req, $time);
        end
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.sig  = model_sig(np_of(k), sd_of(k));
        e.pass = (e.sig == gs_of(k));
        exp_q[k].push_back(e);
    endtask

    // ---------------- DUTs, s27 cores, monitors ----------------
    for (genvar k = 0; k < NI; k++) begin : gi
        logic [2:0] st = 3'(k + 2);   // {G7,G6,G5}, arbitrary power-up state
        logic [3:0] r;
        int         bcnt = 0;
        logic       bd = 1'b0;
        logic       dd = 1'b0;
        logic [7:0] ml = 8'h01;
        logic [3:0] p0 = 4'h0;
        exp_t       e;

        assign r      = s27_step(g[k], st);
        assign g17[k] = r[3];
        always @(posedge clk) st <= r[2:0];

        s27_bist_ctrl #(
            .N_PATTERNS   (np_of(k)),
            .FLUSH_CYCLES (fc_of(k)),
            .LFSR_SEED    (sd_of(k)),
            .GOLDEN_SIG   (gs_of(k))
        ) u_dut (
            .CK        (clk),
            .RST       (rst[k]),
            .START     (start[k]),
            .G0        (g[k][0]),
            .G1        (g[k][1]),
            .G2        (g[k][2]),
            .G3        (g[k][3]),
            .G17       (g17[k]),
            .BUSY      (busy[k]),
            .DONE      (done[k]),
            .PASS      (pass[k]),
            .SIGNATURE (sig[k])
        );

        initial forever begin
            @(negedge clk);
            if (busy[k]) begin
                if (!bd) begin
                    bcnt = 0;
                    ml   = fix_seed(sd_of(k));
                end
                if (bcnt < fc_of(k)) begin
                    check("flush_pat", k, 32'(g[k]), 32'(4'b0011));
                end else begin
                    if (bcnt == fc_of(k)) begin
                        check("s27_state_after_flush", k, 32'(st), 32'(3'b101));
                        p0 = g[k];
                    end
                    check("run_pat", k, 32'(g[k]), 32'(ml[3:0]));
                    if (bcnt - fc_of(k) == 255)
                        check("pat_period", k, 32'(g[k]), 32'(p0));
                    ml = lfsr_adv(ml);
                end
                bcnt++;
            end
            if (done[k])
                check("done_g_zero", k, 32'(g[k]), 0);
            if (done[k] && !dd) begin
                check("busy_len", k, 32'(bcnt), 32'(np_of(k) + fc_of(k)));
                check("exp_pending", k, 32'(exp_q[k].size() > 0), 1);
                if (exp_q[k].size() > 0) begin
                    e = exp_q[k].pop_front();
                    check("signature", k, 32'(sig[k]), 32'(e.sig));
                    check("pass", k, 32'(pass[k]), 32'(e.pass));
                end
            end
            bd = busy[k];
            dd = done[k];
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input int k, input bit expect_run);
        @(negedge clk);
        start[k] = 1'b1;
        if (expect_run) push_exp(k);
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done[k] && t < 1000);
        check("done_seen", k, 32'(done[k]), 1);
    endtask

    task automatic check_idle(input string nm, input int k);
        check({nm, "_g"},    k, 32'(g[k]),    0);
        check({nm, "_busy"}, k, 32'(busy[k]), 0);
        check({nm, "_done"}, k, 32'(done[k]), 0);
        check({nm, "_pass"}, k, 32'(pass[k]), 0);
        check({nm, "_sig"},  k, 32'(sig[k]),  0);
    endtask

    initial begin
        logic [15:0] s1;
        rst   = '1;
        start = '0;

        // Reset values
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) check_idle("rst", k);
        rst = '0;

        // Flush and first patterns, exact timing
        @(negedge clk);
        start[0] = 1'b1;
        push_exp(0);
        for (int ed = 1; ed <= 7; ed++) begin
            @(negedge clk);
            if (ed == 1) start[0] = 1'b0;
            check("t2_busy", 0, 32'(busy[0]), 32'(ed <= 6));
            check("t2_done", 0, 32'(done[0]), 32'(ed == 7));
        end

        // Signature and PASS: matching golden, then golden ^ 1
        pulse_start(1, 1'b1);
        wait_done(1);
        check("t3_pass", 1, 32'(pass[1]), 1);
        pulse_start(2, 1'b1);
        wait_done(2);
        check("t3_fail", 2, 32'(pass[2]), 0);

        // START pulse at RUN cycle 10 is ignored
        pulse_start(1, 1'b1);
        repeat (12) @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_done(1);

        // RST at RUN cycle 10 (with START also high): back to IDLE
        pulse_start(1, 1'b0);
        repeat (12) @(negedge clk);
        rst[1]   = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        check_idle("midrst", 1);
        rst[1]   = 1'b0;
        start[1] = 1'b0;
        @(negedge clk);
        check("midrst_stay_idle", 1, 32'(busy[1]), 0);
        pulse_start(1, 1'b1);
        wait_done(1);

        // START held high: back-to-back runs, one DONE cycle between them
        @(negedge clk);
        start[1] = 1'b1;
        push_exp(1);
        push_exp(1);
        wait_done(1);
        s1 = sig[1];
        @(negedge clk);
        check("held_done_width", 1, 32'(done[1]), 0);
        check("held_rebusy", 1, 32'(busy[1]), 1);
        wait_done(1);
        start[1] = 1'b0;
        check("held_sig_repeat", 1, 32'(sig[1]), 32'(s1));

        // Limits: one pattern, zero seed, more patterns than the LFSR period
        pulse_start(3, 1'b1);
        wait_done(3);
        pulse_start(4, 1'b1);
        wait_done(4);
        pulse_start(5, 1'b1);
        wait_done(5);

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++)
            check("exp_drained", k, 32'(exp_q[k].size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
